// File: rtl/fsmc_pkg.sv
// Shared types and constants for the FSMC transaction sequencer.
//   fsmc_state_t : transaction FSM state encoding
//   ERR_MAX      : saturation value of the error counter
//   TMO_FILL     : data returned on the bus when a read times out
//   sat_inc      : saturating increment for the error counter
package fsmc_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWrite,
        StRdReq,
        StRdDrive,
        StError
    } fsmc_state_t;

    localparam logic [7:0] ERR_MAX = 8'hFF;

    // Wide enough for any supported bus; users slice the low DW bits.
    localparam int unsigned    TMO_FILL_W = 64;
    localparam logic [TMO_FILL_W-1:0] TMO_FILL = '1;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == ERR_MAX) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/fsmc_input_sync.sv
// Bank of 2-flop synchronisers with a per-bit reset value.
//   clk : destination clock
//   rst : asynchronous active-high reset, loads RST_VAL into both stages
//   d   : asynchronous inputs
//   q   : synchronised outputs
module fsmc_input_sync #(
    parameter int unsigned  W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/fsmc_txn_sequencer.sv
// FSMC transaction sequencer: synchronises STM32 FSMC pins into the system clock domain and
// turns each chip-select cycle into a single write strobe or a read request/ack exchange.
//   clk, rst          : system clock, asynchronous active-high reset
//   aNE, aNOE, aNWE   : raw FSMC strobes (active low, asynchronous)
//   aA, aD_in         : raw FSMC address and pad input data (asynchronous)
//   d_out, d_oe       : pad output data and output enable
//   wr_stb/addr/data  : single-cycle write commit to the register bank
//   rd_req/addr       : level read request, held until rd_ack
//   rd_ack, rd_data   : register bank acknowledge with same-cycle data
//   err_count         : saturating count of protocol errors and read timeouts
//   busy              : high whenever the FSM is not idle
module fsmc_txn_sequencer
    import fsmc_pkg::*;
#(
    parameter int unsigned AW     = 4,
    parameter int unsigned DW     = 16,
    parameter int unsigned RD_TMO = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          aNE,
    input  logic          aNOE,
    input  logic          aNWE,
    input  logic [AW-1:0] aA,
    input  logic [DW-1:0] aD_in,
    output logic [DW-1:0] d_out,
    output logic          d_oe,
    output logic          wr_stb,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data,
    output logic          rd_req,
    output logic [AW-1:0] rd_addr,
    input  logic          rd_ack,
    input  logic [DW-1:0] rd_data,
    output logic [7:0]    err_count,
    output logic          busy
);

    localparam logic [7:0] TMO_LIMIT = 8'(RD_TMO);

    // Synchronisers
    logic [2:0]       s_strb;
    logic [AW+DW-1:0] s_ad;
    logic             s_ne, s_noe, s_nwe;
    logic [AW-1:0]    s_a;
    logic [DW-1:0]    s_d;

    fsmc_input_sync #(
        .W       (3),
        .RST_VAL (3'b111)
    ) u_strb_sync (
        .clk (clk),
        .rst (rst),
        .d   ({aNE, aNOE, aNWE}),
        .q   (s_strb)
    );

    fsmc_input_sync #(
        .W       (AW + DW),
        .RST_VAL ('0)
    ) u_ad_sync (
        .clk (clk),
        .rst (rst),
        .d   ({aA, aD_in}),
        .q   (s_ad)
    );

    assign s_ne  = s_strb[2];
    assign s_noe = s_strb[1];
    assign s_nwe = s_strb[0];
    assign s_a   = s_ad[AW+DW-1:DW];
    assign s_d   = s_ad[DW-1:0];

    // FSM state and registered outputs
    fsmc_state_t   state_q, state_d;
    logic          wr_stb_q, wr_stb_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [DW-1:0] wr_data_q, wr_data_d;
    logic          rd_req_q, rd_req_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d;
    logic [DW-1:0] d_out_q, d_out_d;
    logic          oe_q, oe_d;
    logic [7:0]    err_q, err_d;
    logic [7:0]    tmo_q, tmo_d;
    logic [7:0]    tmo_inc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            wr_stb_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            rd_req_q  <= 1'b0;
            rd_addr_q <= '0;
            d_out_q   <= '0;
            oe_q      <= 1'b0;
            err_q     <= '0;
            tmo_q     <= '0;
        end else begin
            state_q   <= state_d;
            wr_stb_q  <= wr_stb_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            rd_req_q  <= rd_req_d;
            rd_addr_q <= rd_addr_d;
            d_out_q   <= d_out_d;
            oe_q      <= oe_d;
            err_q     <= err_d;
            tmo_q     <= tmo_d;
        end
    end

    assign tmo_inc = tmo_q + 8'd1;

    always_comb begin
        state_d   = state_q;
        wr_stb_d  = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        rd_req_d  = rd_req_q;
        rd_addr_d = rd_addr_q;
        d_out_d   = d_out_q;
        oe_d      = oe_q;
        err_d     = err_q;
        tmo_d     = tmo_q;

        unique case (state_q)
            StIdle: begin
                if (!s_ne && !s_noe && !s_nwe) begin
                    state_d = StError;
                    err_d   = sat_inc(err_q);
                end else if (!s_ne && !s_nwe) begin
                    // Capture now too, so a one-cycle NWE pulse still commits valid data.
                    state_d   = StWrite;
                    wr_addr_d = s_a;
                    wr_data_d = s_d;
                end else if (!s_ne && !s_noe) begin
                    state_d   = StRdReq;
                    rd_addr_d = s_a;
                    rd_req_d  = 1'b1;
                    tmo_d     = '0;
                end
            end

            StWrite: begin
                if (!s_noe) begin
                    state_d = StError;
                    err_d   = sat_inc(err_q);
                end else if (s_nwe) begin
                    // Commit on the first cycle NWE is seen high, even if NE rose with it.
                    wr_stb_d = 1'b1;
                    state_d  = StIdle;
                end else if (s_ne) begin
                    state_d = StIdle;
                    err_d   = sat_inc(err_q);
                end else begin
                    wr_addr_d = s_a;
                    wr_data_d = s_d;
                end
            end

            StRdReq: begin
                if (s_ne || s_noe) begin
                    // Host gave up; any later rd_ack is ignored in IDLE.
                    rd_req_d = 1'b0;
                    err_d    = sat_inc(err_q);
                    state_d  = StIdle;
                end else if (rd_ack) begin
                    // Ack has priority over a coincident timeout.
                    d_out_d  = rd_data;
                    rd_req_d = 1'b0;
                    oe_d     = 1'b1;
                    state_d  = StRdDrive;
                end else if (tmo_inc == TMO_LIMIT) begin
                    d_out_d  = TMO_FILL[DW-1:0];
                    rd_req_d = 1'b0;
                    oe_d     = 1'b1;
                    err_d    = sat_inc(err_q);
                    state_d  = StRdDrive;
                end else begin
                    tmo_d = tmo_inc;
                end
            end

            StRdDrive: begin
                if (s_ne || s_noe) begin
                    oe_d    = 1'b0;
                    state_d = StIdle;
                end
            end

            StError: begin
                if (s_ne) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Raw-pin gating lets the pad release as soon as the host deasserts, without sync delay.
    always_comb begin
        busy      = (state_q != StIdle);
        d_oe      = oe_q & ~aNOE & ~aNE;
        d_out     = d_out_q;
        wr_stb    = wr_stb_q;
        wr_addr   = wr_addr_q;
        wr_data   = wr_data_q;
        rd_req    = rd_req_q;
        rd_addr   = rd_addr_q;
        err_count = err_q;
    end

endmodule

// File: tb/tb_fsmc_txn_sequencer.sv
// Scoreboard bench for fsmc_txn_sequencer: stimulus pushes expected writes/reads into queues,
// a monitor pops and compares whenever the DUT presents wr_stb or completes an rd_req pulse.
module tb_fsmc_txn_sequencer;

    localparam int unsigned AW     = 4;
    localparam int unsigned DW     = 16;
    localparam int unsigned RD_TMO = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic          ne, noe, nwe;
    logic [AW-1:0] a;
    logic [DW-1:0] din;
    logic [DW-1:0] d_out;
    logic          d_oe;
    logic          wr_stb;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          rd_ack;
    logic [DW-1:0] rd_data;
    logic [7:0]    err_count;
    logic          busy;

    fsmc_txn_sequencer #(
        .AW     (AW),
        .DW     (DW),
        .RD_TMO (RD_TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .aNE       (ne),
        .aNOE      (noe),
        .aNWE      (nwe),
        .aA        (a),
        .aD_in     (din),
        .d_out     (d_out),
        .d_oe      (d_oe),
        .wr_stb    (wr_stb),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_ack    (rd_ack),
        .rd_data   (rd_data),
        .err_count (err_count),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            cyc;
    } wr_exp_t;

    typedef struct {
        logic [AW-1:0] addr;
        int            cyc;
        int            len;
    } rd_exp_t;

    wr_exp_t wr_q[$];
    rd_exp_t rd_q[$];

    // Register bank model: acks after ack_delay cycles of rd_req, never if negative.
    int ack_delay = -1;
    int req_age   = 0;
    always @(negedge clk) begin
        if (rd_req) begin
            req_age++;
            rd_ack = (ack_delay >= 0) && (req_age == ack_delay + 1);
        end else begin
            req_age = 0;
            rd_ack  = 1'b0;
        end
    end

    // Monitor
    logic          rd_active = 1'b0;
    int            rd_start, rd_len;
    logic [AW-1:0] rd_addr_seen;
    wr_exp_t       we;
    rd_exp_t       re;

    always @(posedge clk) begin
        #1;
        if (rst) begin
            rd_active = 1'b0;
        end else begin
            if (wr_stb) begin
                if (wr_q.size() == 0) begin
                    check("unexpected_wr_stb", 32'd1, 32'd0);
                end else begin
                    we = wr_q.pop_front();
                    check("wr_addr", 32'(wr_addr), 32'(we.addr));
                    check("wr_data", 32'(wr_data), 32'(we.data));
                    check("wr_latency_cycle", cyc, we.cyc);
                end
            end
            if (rd_req) begin
                if (!rd_active) begin
                    rd_active    = 1'b1;
                    rd_start     = cyc;
                    rd_len       = 0;
                    rd_addr_seen = rd_addr;
                end
                rd_len++;
            end else if (rd_active) begin
                rd_active = 1'b0;
                if (rd_q.size() == 0) begin
                    check("unexpected_rd_req", 32'd1, 32'd0);
                end else begin
                    re = rd_q.pop_front();
                    check("rd_addr", 32'(rd_addr_seen), 32'(re.addr));
                    check("rd_req_start_cycle", rd_start, re.cyc);
                    check("rd_req_high_cycles", rd_len, re.len);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_wr(input logic [AW-1:0] ad, input logic [DW-1:0] dt);
        wr_exp_t e;
        e.addr = ad;
        e.data = dt;
        e.cyc  = cyc + 3;
        wr_q.push_back(e);
    endtask

    task automatic push_rd(input logic [AW-1:0] ad, input int len);
        rd_exp_t e;
        e.addr = ad;
        e.cyc  = cyc + 3;
        e.len  = len;
        rd_q.push_back(e);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wr_stb"}, 32'(wr_stb), 32'd0);
        check({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
        check({tag, "_wr_data"}, 32'(wr_data), 32'd0);
        check({tag, "_rd_req"}, 32'(rd_req), 32'd0);
        check({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
        check({tag, "_d_out"}, 32'(d_out), 32'd0);
        check({tag, "_d_oe"}, 32'(d_oe), 32'd0);
        check({tag, "_err_count"}, 32'(err_count), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b1;
        ne      = 1'b1;
        noe     = 1'b1;
        nwe     = 1'b1;
        a       = '0;
        din     = '0;
        rd_data = '0;
        tick(3);
        check_reset_outputs("reset");
        rst = 1'b0;
        tick(3);

        // Write addr 3 / 0xA55A, then a back-to-back write with NE held low.
        a = 4'd3; din = 16'hA55A; ne = 1'b0; nwe = 1'b0;
        tick(10);
        nwe = 1'b1;
        push_wr(4'd3, 16'hA55A);
        tick(3);
        a = 4'hC; din = 16'h5AA5; nwe = 1'b0;
        tick(4);
        nwe = 1'b1;
        push_wr(4'hC, 16'h5AA5);
        tick(5);
        ne = 1'b1;
        tick(4);
        check("write_err_count", 32'(err_count), 32'd0);
        check("write_busy_after", 32'(busy), 32'd0);

        // Read addr 5, ack after 2 cycles with 0x1234.
        ack_delay = 2; rd_data = 16'h1234; a = 4'd5;
        ne = 1'b0; noe = 1'b0;
        push_rd(4'd5, 3);
        tick(10);
        check("read_d_out", 32'(d_out), 32'h1234);
        check("read_d_oe_on", 32'(d_oe), 32'd1);
        check("read_busy", 32'(busy), 32'd1);
        noe = 1'b1;
        #1;
        check("read_d_oe_comb_release", 32'(d_oe), 32'd0);
        tick(1);
        ne = 1'b1;
        tick(4);
        check("read_busy_after", 32'(busy), 32'd0);
        check("read_err_count", 32'(err_count), 32'd0);

        // Read timeout: no ack.
        ack_delay = -1; rd_data = 16'hBEEF; a = 4'd6;
        ne = 1'b0; noe = 1'b0;
        push_rd(4'd6, RD_TMO);
        tick(22);
        check("tmo_d_out", 32'(d_out), 32'hFFFF);
        check("tmo_d_oe", 32'(d_oe), 32'd1);
        check("tmo_err_count", 32'(err_count), 32'd1);
        ne = 1'b1; noe = 1'b1;
        tick(4);

        // Write aborted by NE rising while NWE still low.
        a = 4'd2; din = 16'h1111; ne = 1'b0; nwe = 1'b0;
        tick(5);
        ne = 1'b1;
        tick(4);
        nwe = 1'b1;
        tick(4);
        check("abort_err_count", 32'(err_count), 32'd2);
        check("abort_busy", 32'(busy), 32'd0);

        // NOE and NWE both low under NE.
        ne = 1'b0; noe = 1'b0; nwe = 1'b0;
        tick(5);
        check("error_busy", 32'(busy), 32'd1);
        check("error_rd_req", 32'(rd_req), 32'd0);
        check("error_err_count", 32'(err_count), 32'd3);
        ne = 1'b1; noe = 1'b1; nwe = 1'b1;
        tick(4);
        check("error_err_count_once", 32'(err_count), 32'd3);
        check("error_busy_after", 32'(busy), 32'd0);

        // 300 more error cycles saturate the counter.
        for (int i = 0; i < 300; i++) begin
            ne = 1'b0; noe = 1'b0; nwe = 1'b0;
            tick(4);
            ne = 1'b1; noe = 1'b1; nwe = 1'b1;
            tick(4);
        end
        check("saturated_err_count", 32'(err_count), 32'd255);

        // Reset pulsed mid-read.
        ack_delay = -1; a = 4'd7;
        ne = 1'b0; noe = 1'b0;
        tick(6);
        check("midread_rd_req", 32'(rd_req), 32'd1);
        rst = 1'b1;
        #1;
        check_reset_outputs("midread_rst");
        ne = 1'b1; noe = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(3);

        // Write after reset commits normally.
        a = 4'd9; din = 16'h0F0F; ne = 1'b0; nwe = 1'b0;
        tick(6);
        nwe = 1'b1;
        push_wr(4'd9, 16'h0F0F);
        tick(2);
        ne = 1'b1;
        tick(6);
        check("post_reset_err_count", 32'(err_count), 32'd0);

        tick(5);
        check("wr_queue_drained", wr_q.size(), 32'd0);
        check("rd_queue_drained", rd_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
